// File: rtl/circular_shift_pipelined_barrel.sv
// circular_shift_pipelined_barrel
// Pipelined barrel rotator: rotates an N-bit word left or right by a
// per-word amount (0..N-1) using log2(N) fixed-distance rotate stages
// (1, 2, 4, ...). Valid/ready on both sides. The whole pipe stalls as one
// unit while the output holds a word that the consumer has not taken.
//
// Optional build macro: CIRC_SHIFT_PIPE_EVERY_STAGE_EN
//   defined   -> a register follows every stage (latency L cycles)
//   undefined -> all stages combinational, one output register (latency 1)
// Both builds give the same results and the same handshake.

module circular_shift_pipelined_barrel #(
  parameter int N = 8,
  localparam int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [N-1:0] up_data,
  input  logic [L-1:0] up_amt,
  input  logic         up_dir,
  output logic         down_vld,
  input  logic         down_rdy,
  output logic [N-1:0] down_data
);

  logic stall;

  // Fixed-distance circular shift; left = 1 rotates toward the MSB.
  function automatic logic [N-1:0] rotate_fixed(input logic [N-1:0] d,
                                                input int s,
                                                input logic left);
    if (left) return (d << s) | (d >> (N - s));
    else      return (d >> s) | (d << (N - s));
  endfunction

  // The pipe freezes only when the output slot is full and not being taken.
  assign stall  = down_vld && !down_rdy;
  assign up_rdy = !stall;

`ifdef CIRC_SHIFT_PIPE_EVERY_STAGE_EN

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [N-1:0]   d_in;
    logic           v_in;
    logic           dir_in;
    logic [L-1-k:0] amt_in;
    logic [N-1:0]   q_data;
    logic           q_vld;

    if (k == 0) begin : g_first
      assign d_in   = up_data;
      assign v_in   = up_vld;
      assign dir_in = up_dir;
      assign amt_in = up_amt;
    end else begin : g_next
      assign d_in   = g_stage[k-1].q_data;
      assign v_in   = g_stage[k-1].q_vld;
      assign dir_in = g_stage[k-1].g_carry.q_dir;
      assign amt_in = g_stage[k-1].g_carry.q_amt;
    end

    // Stage register: rotate by 2^k when this stage's amount bit is set;
    // data is only loaded for real words so bubbles do not toggle it.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_vld  <= 1'b0;
        q_data <= '0;
      end else if (!stall) begin
        q_vld <= v_in;
        if (v_in) q_data <= amt_in[0] ? rotate_fixed(d_in, 1 << k, dir_in) : d_in;
      end
    end

    // Direction and the still-unused amount bits ride along to later stages.
    if (k < L - 1) begin : g_carry
      logic           q_dir;
      logic [L-2-k:0] q_amt;

      // Carry the control fields in lock-step with the stage data.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_dir <= 1'b0;
          q_amt <= '0;
        end else if (!stall && v_in) begin
          q_dir <= dir_in;
          q_amt <= amt_in[L-1-k:1];
        end
      end
    end
  end

  assign down_data = g_stage[L-1].q_data;
  assign down_vld  = g_stage[L-1].q_vld;

`else

  logic [N-1:0] rot_data;

  // All rotate stages chained combinationally, stage k moving by 2^k.
  always_comb begin
    rot_data = up_data;
    for (int k = 0; k < L; k++) begin
      if (up_amt[k]) rot_data = rotate_fixed(rot_data, 1 << k, up_dir);
    end
  end

  // Single output register; data is only loaded for real words.
  always_ff @(posedge clk) begin
    if (rst) begin
      down_vld  <= 1'b0;
      down_data <= '0;
    end else if (!stall) begin
      down_vld <= up_vld;
      if (up_vld) down_data <= rot_data;
    end
  end

`endif

endmodule

// File: tb/tb_circular_shift_pipelined_barrel.sv
// tb_circular_shift_pipelined_barrel
// Directed bench for the pipelined barrel rotator (N = 8). Results are
// gathered into a queue as they transfer out, and each check is an
// immediate assertion against a hand-computed value.

module tb_circular_shift_pipelined_barrel;

  logic       clk;
  logic       rst;
  logic       up_vld;
  logic       up_rdy;
  logic [7:0] up_data;
  logic [2:0] up_amt;
  logic       up_dir;
  logic       down_vld;
  logic       down_rdy;
  logic [7:0] down_data;

  int total;
  int bad;
  logic [7:0] out_q[$];

  logic [7:0] bp_data[6] = '{8'hA5, 8'h3C, 8'h81, 8'hF0, 8'h12, 8'h6B};
  logic [2:0] bp_amt[6]  = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd6};
  logic       bp_dir[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] bp_exp[6]  = '{8'h4B, 8'h0F, 8'h18, 8'h87, 8'h09, 8'hAD};

  circular_shift_pipelined_barrel #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (up_vld),
    .up_rdy    (up_rdy),
    .up_data   (up_data),
    .up_amt    (up_amt),
    .up_dir    (up_dir),
    .down_vld  (down_vld),
    .down_rdy  (down_rdy),
    .down_data (down_data)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock: entered and left at a negedge; records accept and any
  // result transferred on the posedge in between.
  task automatic runCycle(output bit accepted);
    bit         send_out;
    logic [7:0] od;
    #1;
    accepted = up_vld && up_rdy && !rst;
    send_out = down_vld && down_rdy && !rst;
    od       = down_data;
    @(posedge clk);
    if (send_out) out_q.push_back(od);
    @(negedge clk);
  endtask

  // Send one word with the consumer always ready and check its result.
  task automatic applyStimulus(input string tag, input logic [7:0] d,
                               input logic [2:0] a, input logic dr,
                               input logic [7:0] expected);
    bit acc;
    int cyc;
    out_q.delete();
    down_rdy = 1'b1;
    up_vld   = 1'b1;
    up_data  = d;
    up_amt   = a;
    up_dir   = dr;
    acc      = 1'b0;
    cyc      = 0;
    while (!acc && cyc < 10) begin
      runCycle(acc);
      cyc++;
    end
    up_vld = 1'b0;
    up_data = 8'h00;
    cyc = 0;
    while (out_q.size() == 0 && cyc < 10) begin
      runCycle(acc);
      cyc++;
    end
    runCycle(acc);
    checkOutput({tag, "_count"}, out_q.size(), 1);
    checkOutput(tag, (out_q.size() > 0) ? {24'h0, out_q[0]} : 32'hDEADBEEF,
                {24'h0, expected});
  endtask

  initial begin
    bit         acc;
    int         i;
    int         n;
    int         cyc;
    int         stall_left;
    bit         stall_started;
    logic [7:0] held;

    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    up_vld   = 1'b0;
    up_data  = 8'h00;
    up_amt   = 3'd0;
    up_dir   = 1'b0;
    down_rdy = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_down_vld", down_vld, 0);
    checkOutput("reset_down_data", down_data, 0);
    rst = 1'b0;
    #1;
    checkOutput("reset_up_rdy", up_rdy, 1);
    @(negedge clk);

    // Basic rotations
    applyStimulus("rot_r3", 8'b10110101, 3'd3, 1'b0, 8'b10110110);
    applyStimulus("rot_l3", 8'b10110101, 3'd3, 1'b1, 8'b10101101);
    applyStimulus("amt0_r", 8'b01100110, 3'd0, 1'b0, 8'b01100110);
    applyStimulus("amt0_l", 8'b01100110, 3'd0, 1'b1, 8'b01100110);

    // One-hot sweep to the right, then the far left edge case
    applyStimulus("sweep_r0", 8'h80, 3'd0, 1'b0, 8'h80);
    applyStimulus("sweep_r1", 8'h80, 3'd1, 1'b0, 8'h40);
    applyStimulus("sweep_r2", 8'h80, 3'd2, 1'b0, 8'h20);
    applyStimulus("sweep_r3", 8'h80, 3'd3, 1'b0, 8'h10);
    applyStimulus("sweep_r4", 8'h80, 3'd4, 1'b0, 8'h08);
    applyStimulus("sweep_r5", 8'h80, 3'd5, 1'b0, 8'h04);
    applyStimulus("sweep_r6", 8'h80, 3'd6, 1'b0, 8'h02);
    applyStimulus("sweep_r7", 8'h80, 3'd7, 1'b0, 8'h01);
    applyStimulus("left_7", 8'h01, 3'd7, 1'b1, 8'h80);

    // Backpressure: stream 6 words, stall the consumer for 4 cycles
    out_q.delete();
    i             = 0;
    cyc           = 0;
    stall_left    = 0;
    stall_started = 1'b0;
    held          = 8'h00;
    down_rdy      = 1'b1;
    while ((i < 6 || out_q.size() < 6) && cyc < 80) begin
      if (!stall_started && down_vld) begin
        stall_started = 1'b1;
        stall_left    = 4;
        held          = down_data;
      end
      down_rdy = (stall_left == 0);
      up_vld   = (i < 6);
      if (i < 6) begin
        up_data = bp_data[i];
        up_amt  = bp_amt[i];
        up_dir  = bp_dir[i];
      end
      if (stall_left > 0) begin
        #1;
        checkOutput("bp_up_rdy_low", up_rdy, 0);
        checkOutput("bp_data_stable", down_data, held);
        checkOutput("bp_vld_stable", down_vld, 1);
      end
      runCycle(acc);
      if (acc) i++;
      if (stall_left > 0) stall_left--;
      cyc++;
    end
    up_vld   = 1'b0;
    down_rdy = 1'b1;
    for (int k = 0; k < 6; k++) runCycle(acc);
    checkOutput("bp_no_timeout", (cyc < 80), 1);
    checkOutput("bp_stall_seen", stall_started, 1);
    checkOutput("bp_count", out_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("bp_word%0d", k),
                  (out_q.size() > k) ? {24'h0, out_q[k]} : 32'hDEADBEEF,
                  {24'h0, bp_exp[k]});
    end

    // Reset mid-stream: fill the pipe with the consumer blocked, then reset
    out_q.delete();
    down_rdy = 1'b0;
    n        = 0;
    cyc      = 0;
    while (n < 3 && cyc < 10) begin
      up_vld  = 1'b1;
      up_data = bp_data[n];
      up_amt  = bp_amt[n];
      up_dir  = bp_dir[n];
      runCycle(acc);
      if (acc) n++;
      cyc++;
    end
    up_vld = 1'b0;
    checkOutput("rst_pre_inflight", (n > 0), 1);
    rst = 1'b1;
    runCycle(acc);
    rst = 1'b0;
    #1;
    checkOutput("rst_down_vld", down_vld, 0);
    checkOutput("rst_up_rdy", up_rdy, 1);
    down_rdy = 1'b1;
    for (int k = 0; k < 10; k++) runCycle(acc);
    checkOutput("rst_no_leak", out_q.size(), 0);
    applyStimulus("rst_after", 8'b10110101, 3'd3, 1'b0, 8'b10110110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
